lap_recall_reader: RTL

// - Read side of the stopwatch lap store.
// - Walks the five 21-bit lap slots {m[6:0], s[6:0], sms[6:0]} and their per-slot empty flags, and presents one lap at a time to the display path.
// - The user steps forward and back with two buttons; selection wraps over the filled slots only.
// - Sits between the lap store and the 7-segment formatter. Active only while recall mode is on.

---
 rtl/lap_recall_reader_pkg.sv | 27 ++
 rtl/lap_recall_reader_btn_edge_sync.sv | 30 +++
 rtl/lap_recall_reader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lap_recall_reader_pkg.sv
// Shared definitions for the lap recall reader: state encodings, lap field slices, slot count.
package lap_recall_reader_pkg;

  localparam int NSLOT      = 5;
  localparam int LAP_W      = 21;
  localparam int LAP_M_HI   = 20;
  localparam int LAP_M_LO   = 14;
  localparam int LAP_S_HI   = 13;
  localparam int LAP_S_LO   = 7;
  localparam int LAP_SMS_HI = 6;
  localparam int LAP_SMS_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_EMPTY = 2'd2
  } state_e;

  // Number of filled slots before the first empty one; slots fill strictly in order.
  function automatic logic [2:0] lead_count(input logic [NSLOT-1:0] empty);
    lead_count = 3'(NSLOT);
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (empty[i]) lead_count = 3'(i);
    end
  endfunction

endpackage

// File: rtl/lap_recall_reader_btn_edge_sync.sv
// Button conditioner: 2-flop synchroniser, then a registered one-cycle rising-edge pulse
// appearing 3 clk after the raw input rises.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [2:0] sync_q, sync_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[1:0], btn};
    pulse_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/lap_recall_reader.sv
// Read side of the lap store: steps through filled lap slots and registers the shown lap.
// Define LAP_AUTOSCROLL_EN to add a timed auto-advance every SCROLL_TICKS clk while showing.
module lap_recall_reader
  import lap_recall_reader_pkg::*;
`ifdef LAP_AUTOSCROLL_EN
#(
  parameter int SCROLL_TICKS = 50000000
)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        recall_on,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic [20:0] dat1,
  input  logic [20:0] dat2,
  input  logic [20:0] dat3,
  input  logic [20:0] dat4,
  input  logic [20:0] dat5,
  input  logic        o1,
  input  logic        o2,
  input  logic        o3,
  input  logic        o4,
  input  logic        o5,
  output logic [6:0]  lap_m,
  output logic [6:0]  lap_s,
  output logic [6:0]  lap_sms,
  output logic [2:0]  lap_num,
  output logic        lap_valid
);

  logic nxt_p, prv_p;

  btn_edge_sync u_next (.clk(clk), .rst_n(reset_n), .btn(btn_next), .pulse(nxt_p));
  btn_edge_sync u_prev (.clk(clk), .rst_n(reset_n), .btn(btn_prev), .pulse(prv_p));

  logic [NSLOT-1:0][LAP_W-1:0] dat;
  logic [2:0]                  count;
  assign dat   = {dat5, dat4, dat3, dat2, dat1};
  assign count = lead_count({o5, o4, o3, o2, o1});

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       step_fwd, step_back;

`ifdef LAP_AUTOSCROLL_EN
  localparam int CW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  logic [CW-1:0] scroll_q, scroll_d;
  logic          auto_tick;

  assign auto_tick = (scroll_q == CW'(SCROLL_TICKS - 1));
  // A manual pulse owns the cycle; the auto tick only counts when no button fired.
  assign step_fwd  = (nxt_p & ~prv_p) | (auto_tick & ~nxt_p & ~prv_p);
  assign step_back = prv_p & ~nxt_p;

  always_comb begin
    scroll_d = '0;
    if (state_q == ST_SHOW && state_d == ST_SHOW && !nxt_p && !prv_p && !auto_tick)
      scroll_d = scroll_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scroll_q <= '0;
    else          scroll_q <= scroll_d;
  end
`else
  assign step_fwd  = nxt_p & ~prv_p;
  assign step_back = prv_p & ~nxt_p;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (recall_on) begin
          state_d = (count == 3'd0) ? ST_EMPTY : ST_SHOW;
          idx_d   = '0;
        end
      end
      ST_SHOW: begin
        if (!recall_on) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (count == 3'd0) begin
          state_d = ST_EMPTY;
          idx_d   = '0;
        end else if (count <= idx_q) begin
          idx_d = '0;
        end else if (step_fwd) begin
          idx_d = (idx_q == count - 3'd1) ? 3'd0 : idx_q + 3'd1;
        end else if (step_back) begin
          idx_d = (idx_q == 3'd0) ? count - 3'd1 : idx_q - 3'd1;
        end
      end
      ST_EMPTY: begin
        if (!recall_on) begin
          state_d = ST_IDLE;
        end else if (count != 3'd0) begin
          state_d = ST_SHOW;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  logic [LAP_W-1:0] show_dat;
  logic [6:0]       m_q, m_d, s_q, s_d, sms_q, sms_d;
  logic [2:0]       num_q, num_d;
  logic             valid_q, valid_d;

  assign show_dat = dat[idx_q];

  always_comb begin
    m_d     = '0;
    s_d     = '0;
    sms_d   = '0;
    num_d   = '0;
    valid_d = 1'b0;
    if (state_q == ST_SHOW) begin
      m_d     = show_dat[LAP_M_HI:LAP_M_LO];
      s_d     = show_dat[LAP_S_HI:LAP_S_LO];
      sms_d   = show_dat[LAP_SMS_HI:LAP_SMS_LO];
      num_d   = idx_q + 3'd1;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      m_q     <= '0;
      s_q     <= '0;
      sms_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      s_q     <= s_d;
      sms_q   <= sms_d;
      num_q   <= num_d;
      valid_q <= valid_d;
    end
  end

  assign lap_m     = m_q;
  assign lap_s     = s_q;
  assign lap_sms   = sms_q;
  assign lap_num   = num_q;
  assign lap_valid = valid_q;

endmodule
